// File: rtl/knn_distance_unit.sv
// rtl/knn_distance_unit.sv - streaming k-NN distance unit against a stored reference vector
//
// Purpose: holds one N-dimensional reference vector and, for each incoming sample
// vector (N value beats followed by one label beat), produces the squared Euclidean
// distance (or L1 distance when KNN_DIST_MANHATTAN_EN is defined) through a
// single-slot output register with a valid/ready handshake.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous active-low reset
//   loadRef      reference-load mode request
//   refDataIn    reference value, written while in LOAD
//   dataValid    qualifies dataValueIn / dataNameIn
//   dataValueIn  sample dimension value
//   dataNameIn   vector label, taken on the (N+1)th accepted beat
//   dataReady    beat accepted when dataValid & dataReady
//   done         end of sample stream
//   dataNameOut  label of finished vector
//   distOut      distance of finished vector
//   outValid     output slot holds a result
//   outReady     consumer accepts the result
//   doneOut      stream finished and output drained (held until reset)
//   err          sticky protocol error
//
// Optional feature macro: KNN_DIST_MANHATTAN_EN (L1 distance instead of squared L2).

module knn_distance_unit #(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 5
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   loadRef,
  input  logic [dataWidth-1:0]                                   refDataIn,
  input  logic                                                   dataValid,
  input  logic [dataWidth-1:0]                                   dataValueIn,
  input  logic [31:0]                                            dataNameIn,
  output logic                                                   dataReady,
  input  logic                                                   done,
  output logic [31:0]                                            dataNameOut,
  output logic [2*dataWidth+$clog2(numberOfDimensions)-1:0]      distOut,
  output logic                                                   outValid,
  input  logic                                                   outReady,
  output logic                                                   doneOut,
  output logic                                                   err
);

  localparam int N  = numberOfDimensions;
  localparam int DW = 2*dataWidth + $clog2(N);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, NAME, FINISH} state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        cnt;
  logic [DW-1:0]        acc;
  logic [dataWidth-1:0] ref_mem [N];
  logic                 ref_loaded;

  logic [dataWidth-1:0] ref_val;
  logic [dataWidth-1:0] diff;
  logic [DW-1:0]        term;
  logic                 beat;

`ifndef KNN_DIST_MANHATTAN_EN
  logic [2*dataWidth-1:0] diff_ext;
  logic [2*dataWidth-1:0] sq;
`endif

  // Magnitude is taken before squaring so the unsigned operands never wrap.
  always_comb begin
    ref_val = ref_mem[cnt];
    diff    = (dataValueIn >= ref_val) ? (dataValueIn - ref_val) : (ref_val - dataValueIn);
`ifdef KNN_DIST_MANHATTAN_EN
    term    = DW'(diff);
`else
    diff_ext = {{dataWidth{1'b0}}, diff};
    sq       = diff_ext * diff_ext;
    term     = DW'(sq);
`endif
  end

  // The label beat is held off only while the single output slot is occupied;
  // value beats never touch the slot so ACCUM always accepts.
  always_comb begin
    dataReady = 1'b0;
    if (state == ACCUM)
      dataReady = 1'b1;
    else if (state == NAME)
      dataReady = !(outValid && !outReady);
  end

  assign beat = dataValid && dataReady;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      acc         <= '0;
      ref_loaded  <= 1'b0;
      outValid    <= 1'b0;
      doneOut     <= 1'b0;
      err         <= 1'b0;
      dataNameOut <= '0;
      distOut     <= '0;
      for (int i = 0; i < N; i++)
        ref_mem[i] <= '0;
    end else begin
      // Drain the slot; a result loaded below in the same cycle overrides this.
      if (outValid && outReady)
        outValid <= 1'b0;

      if (state == FINISH && !outValid)
        doneOut <= 1'b1;

      unique case (state)
        IDLE: begin
          if (loadRef) begin
            state      <= LOAD;
            idx        <= '0;
            ref_loaded <= 1'b0;
          end
        end

        LOAD: begin
          if (loadRef) begin
            if (idx < IW'(N)) begin
              ref_mem[idx[CW-1:0]] <= refDataIn;
              idx                  <= idx + 1'b1;
              ref_loaded           <= (idx == IW'(N - 1));
            end else begin
              // Overlong load: the write is dropped and the reference is not trusted.
              err        <= 1'b1;
              ref_loaded <= 1'b0;
            end
          end else if (ref_loaded) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
          end else begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end

        ACCUM: begin
          if (loadRef) begin
            err        <= 1'b1;
            state      <= LOAD;
            idx        <= '0;
            ref_loaded <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
          end else if (done) begin
            if (cnt != '0)
              err <= 1'b1;
            state <= FINISH;
            acc   <= '0;
            cnt   <= '0;
          end else if (beat) begin
            acc <= acc + term;
            if (cnt == CW'(N - 1)) begin
              cnt   <= '0;
              state <= NAME;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        NAME: begin
          if (loadRef) begin
            err        <= 1'b1;
            state      <= LOAD;
            idx        <= '0;
            ref_loaded <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
          end else if (done) begin
            // A fully accumulated vector without its label is still incomplete.
            err   <= 1'b1;
            state <= FINISH;
            acc   <= '0;
            cnt   <= '0;
          end else if (beat) begin
            dataNameOut <= dataNameIn;
            distOut     <= acc;
            outValid    <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
            state       <= ACCUM;
          end
        end

        FINISH: begin
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_distance_unit.sv
// tb/tb_knn_distance_unit.sv - self-checking bench for knn_distance_unit

module tb_knn_distance_unit;

  localparam int W  = 32;
  localparam int N  = 5;
  localparam int DW = 2*W + $clog2(N);

`ifdef KNN_DIST_MANHATTAN_EN
  localparam logic [DW-1:0] E_V0 = 27;
  localparam logic [DW-1:0] E_ONES = 5;
  localparam logic [DW-1:0] E_TWOS = 2;
  localparam logic [DW-1:0] E_FIVES = 15;
  localparam logic [DW-1:0] E_THREES = 5;
  localparam logic [DW-1:0] E_ZEROS = 10;
`else
  localparam logic [DW-1:0] E_V0 = 163;
  localparam logic [DW-1:0] E_ONES = 7;
  localparam logic [DW-1:0] E_TWOS = 2;
  localparam logic [DW-1:0] E_FIVES = 47;
  localparam logic [DW-1:0] E_THREES = 7;
  localparam logic [DW-1:0] E_ZEROS = 22;
`endif

  typedef logic [W-1:0] vec_t [N];

  logic          clk;
  logic          reset;
  logic          loadRef;
  logic [W-1:0]  refDataIn;
  logic          dataValid;
  logic [W-1:0]  dataValueIn;
  logic [31:0]   dataNameIn;
  logic          dataReady;
  logic          done;
  logic [31:0]   dataNameOut;
  logic [DW-1:0] distOut;
  logic          outValid;
  logic          outReady;
  logic          doneOut;
  logic          err;

  knn_distance_unit #(.dataWidth(W), .numberOfDimensions(N)) dut (
    .clk(clk), .reset(reset), .loadRef(loadRef), .refDataIn(refDataIn),
    .dataValid(dataValid), .dataValueIn(dataValueIn), .dataNameIn(dataNameIn),
    .dataReady(dataReady), .done(done), .dataNameOut(dataNameOut), .distOut(distOut),
    .outValid(outValid), .outReady(outReady), .doneOut(doneOut), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vec_t          model_ref;
  logic [31:0]   exp_name_q [$];
  logic [DW-1:0] exp_dist_q [$];

  function automatic logic [DW-1:0] model_dist(input vec_t v);
    logic [DW-1:0] s, a, b, d;
    s = '0;
    for (int i = 0; i < N; i++) begin
      a = DW'(v[i]);
      b = DW'(model_ref[i]);
      d = (a > b) ? a - b : b - a;
`ifdef KNN_DIST_MANHATTAN_EN
      s = s + d;
`else
      s = s + d * d;
`endif
    end
    return s;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    loadRef = 1'b0; dataValid = 1'b0; done = 1'b0;
    refDataIn = '0; dataValueIn = '0; dataNameIn = '0;
    exp_name_q.delete();
    exp_dist_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic load_ref(input vec_t v, input int n);
    loadRef = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      refDataIn = (i < N) ? v[i] : 32'hDEAD;
      tick();
    end
    loadRef = 1'b0;
    tick();
    if (n == N) model_ref = v;
  endtask

  task automatic send_beat(input logic [W-1:0] val, input logic [31:0] name, output logic stalled);
    logic ok;
    ok = 1'b0;
    stalled = 1'b0;
    dataValid = 1'b1;
    dataValueIn = val;
    dataNameIn = name;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge clk);
      if (dataReady) ok = 1'b1;
      else stalled = 1'b1;
      @(posedge clk);
      #1;
    end
    dataValid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_timeout: actual not_accepted required accepted");
    end
  endtask

  task automatic send_vector(input vec_t v, input logic [31:0] name, output logic name_stalled);
    logic st;
    logic [DW-1:0] e;
    for (int i = 0; i < N; i++) send_beat(v[i], 32'hFFFF_FFFF, st);
    e = model_dist(v);
    exp_name_q.push_back(name);
    exp_dist_q.push_back(e);
    send_beat('0, name, name_stalled);
    check("out_valid_after_name", outValid, 1);
    check("name_after_name_beat", dataNameOut, name);
    check("dist_after_name_beat", distOut, e);
  endtask

  task automatic wait_done_out();
    for (int g = 0; g < 20 && !doneOut; g++) tick();
    check("done_out", doneOut, 1);
  endtask

  // Compare process: every completed output handshake must match the model's
  // next expected result, and a stalled result must not change.
  logic          hold_prev = 1'b0;
  logic [31:0]   name_prev;
  logic [DW-1:0] dist_prev;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (hold_prev) begin
        check("hold_valid", outValid, 1);
        check("hold_name", dataNameOut, name_prev);
        check("hold_dist", distOut, dist_prev);
      end
      if (outValid === 1'b1 && outReady === 1'b1) begin
        if (exp_name_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: actual name %0d dist %0d required none", dataNameOut, distOut);
        end else begin
          check("stream_name", dataNameOut, exp_name_q.pop_front());
          check("stream_dist", distOut, exp_dist_q.pop_front());
        end
      end
    end
    hold_prev = (reset === 1'b1) && (outValid === 1'b1) && (outReady === 1'b0);
    name_prev = dataNameOut;
    dist_prev = distOut;
  end

  initial begin
    vec_t refv, v0, ones, twos, fives, threes, zeros;
    logic st;
    refv   = '{32'd1, 32'd2, 32'd2, 32'd2, 32'd3};
    v0     = '{32'd5, 32'd10, 32'd7, 32'd9, 32'd6};
    ones   = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    twos   = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
    fives  = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
    threes = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
    zeros  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    outReady = 1'b1;

    do_reset();
    check("rst_data_ready", dataReady, 0);
    check("rst_out_valid", outValid, 0);
    check("rst_done_out", doneOut, 0);
    check("rst_err", err, 0);
    check("rst_dist", distOut, 0);
    check("rst_name", dataNameOut, 0);

    load_ref(refv, N);
    check("load_err", err, 0);
    check("accum_ready", dataReady, 1);

    send_vector(v0, 32'd0, st);
    check("lit_v0", distOut, E_V0);

    send_vector(ones, 32'd1, st);
    check("lit_ones", distOut, E_ONES);
    send_vector(twos, 32'd2, st);
    check("lit_twos", distOut, E_TWOS);
    send_vector(fives, 32'd3, st);
    check("lit_fives", distOut, E_FIVES);
    repeat (3) tick();

    outReady = 1'b0;
    send_vector(threes, 32'd10, st);
    check("lit_threes", distOut, E_THREES);
    fork
      begin
        repeat (10) tick();
        outReady = 1'b1;
      end
      begin
        send_vector(zeros, 32'd11, st);
        check("name_stalled", st, 1);
        check("lit_zeros", distOut, E_ZEROS);
      end
    join
    repeat (3) tick();

    done = 1'b1;
    tick();
    done = 1'b0;
    wait_done_out();
    check("clean_done_err", err, 0);
    check("finish_ready", dataReady, 0);

    do_reset();
    load_ref(refv, 6);
    check("six_writes_err", err, 1);

    do_reset();
    load_ref(refv, 4);
    check("four_writes_err", err, 1);
    check("four_writes_ready", dataReady, 0);

    do_reset();
    load_ref(refv, N);
    outReady = 1'b0;
    send_vector(v0, 32'd5, st);
    for (int i = 0; i < 3; i++) send_beat(32'd9, 32'hFFFF_FFFF, st);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("partial_err", err, 1);
    check("done_out_blocked", doneOut, 0);
    outReady = 1'b1;
    wait_done_out();

    do_reset();
    load_ref(refv, N);
    outReady = 1'b0;
    send_vector(ones, 32'd7, st);
    reset = 1'b0;
    exp_name_q.delete();
    exp_dist_q.delete();
    tick();
    check("mid_rst_ready", dataReady, 0);
    check("mid_rst_valid", outValid, 0);
    check("mid_rst_done_out", doneOut, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_dist", distOut, 0);
    check("mid_rst_name", dataNameOut, 0);
    reset = 1'b1;
    outReady = 1'b1;
    repeat (2) tick();

    check("results_left", exp_name_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
